// File: rtl/bsw_band_ctrl_if.sv
// Signal bundle between the band controller, its host, the max-16 unit and the PE array.
// The controller takes the slave side; a host or testbench drives the master side.
interface bsw_band_ctrl_if #(
   parameter int LEN_W = 10
);
   logic             start;
   logic [LEN_W-1:0] ref_len;
   logic [LEN_W-1:0] qry_len;
   logic             ma_valid;
   logic [6:0]       ma_out;
   logic [3:0]       ma_p;
   logic             r_shift;
   logic             d_shift;
   logic             pe_en;
   logic             shift_right;
   logic             shift_down;
   logic             busy;
   logic             done;
   logic [1:0]       done_reason;
   logic [6:0]       best_score;
   logic [LEN_W-1:0] best_ref;
   logic [LEN_W-1:0] best_qry;
   logic [LEN_W:0]   step_cnt;

   modport master (
      output start, ref_len, qry_len, ma_valid, ma_out, ma_p, r_shift, d_shift,
      input  pe_en, shift_right, shift_down, busy, done, done_reason,
             best_score, best_ref, best_qry, step_cnt
   );

   modport slave (
      input  start, ref_len, qry_len, ma_valid, ma_out, ma_p, r_shift, d_shift,
      output pe_en, shift_right, shift_down, busy, done, done_reason,
             best_score, best_ref, best_qry, step_cnt
   );
endinterface

// File: rtl/bsw_band_ctrl.sv
// Step sequencer for the 16-PE banded Smith-Waterman array: issues one anti-diagonal step,
// waits for the row maximum, tracks the best cell and steers the band right or down.
module bsw_band_ctrl #(
   parameter int LEN_W     = 10,
   parameter int XDROP     = 20,
   parameter int MAX_STEPS = 1023
) (
   input  logic           clk,
   input  logic           rst_n,
   bsw_band_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      WAIT = 2'd2,
      FIN  = 2'd3
   } state_t;

   localparam logic [1:0]       REASON_END   = 2'd0;
   localparam logic [1:0]       REASON_XDROP = 2'd1;
   localparam logic [1:0]       REASON_LIMIT = 2'd2;
   localparam logic             DIR_R        = 1'b0;
   localparam logic             DIR_D        = 1'b1;
   localparam logic [LEN_W:0]   BAND         = {{(LEN_W-4){1'b0}}, 5'd16};
   localparam logic [LEN_W-1:0] PE_LAST      = {{(LEN_W-4){1'b0}}, 4'd15};
   localparam logic [LEN_W:0]   MAX_STEPS_C  = MAX_STEPS[LEN_W:0];
   localparam logic [6:0]       XDROP_C      = XDROP[6:0];

   state_t           state_q, state_d;
   logic [LEN_W-1:0] ref_len_q, ref_len_d;
   logic [LEN_W-1:0] qry_len_q, qry_len_d;
   logic [LEN_W-1:0] ref_ptr_q, ref_ptr_d;
   logic [LEN_W-1:0] qry_ptr_q, qry_ptr_d;
   logic [6:0]       best_score_q, best_score_d;
   logic [LEN_W-1:0] best_ref_q, best_ref_d;
   logic [LEN_W-1:0] best_qry_q, best_qry_d;
   logic [LEN_W:0]   step_cnt_q, step_cnt_d;
   logic [1:0]       done_reason_q, done_reason_d;
   logic             first_q, first_d;
   logic             dir_q, dir_d;

   logic [LEN_W-1:0] p_ext;
   logic             best_upd;
   logic [6:0]       best_new;
   logic [6:0]       drop;
   logic [LEN_W:0]   ref_reach;
   logic [LEN_W:0]   qry_reach;
   logic             can_r, can_d;
   logic             r_hint, d_hint;
   logic             xdrop_hit, limit_hit, end_hit;
   logic             dir_next;

   // Evaluation of the max-unit result against the pointers of the step just issued
   always_comb begin
      p_ext     = {{(LEN_W-4){1'b0}}, bus.ma_p};
      best_upd  = bus.ma_out > best_score_q;
      best_new  = best_upd ? bus.ma_out : best_score_q;
      drop      = best_new - bus.ma_out;
      ref_reach = {1'b0, ref_ptr_q} + BAND;
      qry_reach = {1'b0, qry_ptr_q} + BAND;
      can_r     = ref_reach < {1'b0, ref_len_q};
      can_d     = qry_reach < {1'b0, qry_len_q};
      xdrop_hit = drop > XDROP_C;
      limit_hit = step_cnt_q == MAX_STEPS_C;
      end_hit   = !can_r && !can_d;
      // Both hints high is illegal and treated as no hint at all
      r_hint    = bus.r_shift && !bus.d_shift;
      d_hint    = bus.d_shift && !bus.r_shift;
      if (r_hint && can_r) begin
         dir_next = DIR_R;
      end else if (d_hint && can_d) begin
         dir_next = DIR_D;
      end else if (can_r && !can_d) begin
         dir_next = DIR_R;
      end else if (can_d && !can_r) begin
         dir_next = DIR_D;
      end else begin
         dir_next = !dir_q;
      end
   end

   always_comb begin
      state_d       = state_q;
      ref_len_d     = ref_len_q;
      qry_len_d     = qry_len_q;
      ref_ptr_d     = ref_ptr_q;
      qry_ptr_d     = qry_ptr_q;
      best_score_d  = best_score_q;
      best_ref_d    = best_ref_q;
      best_qry_d    = best_qry_q;
      step_cnt_d    = step_cnt_q;
      done_reason_d = done_reason_q;
      first_d       = first_q;
      dir_d         = dir_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               ref_len_d     = bus.ref_len;
               qry_len_d     = bus.qry_len;
               ref_ptr_d     = '0;
               qry_ptr_d     = '0;
               best_score_d  = '0;
               best_ref_d    = '0;
               best_qry_d    = '0;
               step_cnt_d    = '0;
               done_reason_d = REASON_END;
               first_d       = 1'b1;
               // Pretend the last move was down so alternation opens with a right move
               dir_d         = DIR_D;
               state_d       = STEP;
            end
         end
         STEP: begin
            step_cnt_d = step_cnt_q + 1'b1;
            if (first_q) begin
               first_d = 1'b0;
            end else if (dir_q == DIR_D) begin
               qry_ptr_d = qry_ptr_q + 1'b1;
            end else begin
               ref_ptr_d = ref_ptr_q + 1'b1;
            end
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.ma_valid) begin
               best_score_d = best_new;
               if (best_upd) begin
                  best_ref_d = ref_ptr_q + p_ext;
                  best_qry_d = qry_ptr_q + PE_LAST - p_ext;
               end
               dir_d   = dir_next;
               state_d = STEP;
               if (xdrop_hit) begin
                  done_reason_d = REASON_XDROP;
                  state_d       = FIN;
               end else if (limit_hit) begin
                  done_reason_d = REASON_LIMIT;
                  state_d       = FIN;
               end else if (end_hit) begin
                  done_reason_d = REASON_END;
                  state_d       = FIN;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ref_len_q     <= '0;
         qry_len_q     <= '0;
         ref_ptr_q     <= '0;
         qry_ptr_q     <= '0;
         best_score_q  <= '0;
         best_ref_q    <= '0;
         best_qry_q    <= '0;
         step_cnt_q    <= '0;
         done_reason_q <= '0;
         first_q       <= 1'b0;
         dir_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         ref_len_q     <= ref_len_d;
         qry_len_q     <= qry_len_d;
         ref_ptr_q     <= ref_ptr_d;
         qry_ptr_q     <= qry_ptr_d;
         best_score_q  <= best_score_d;
         best_ref_q    <= best_ref_d;
         best_qry_q    <= best_qry_d;
         step_cnt_q    <= step_cnt_d;
         done_reason_q <= done_reason_d;
         first_q       <= first_d;
         dir_q         <= dir_d;
      end
   end

   // The initial band load carries no shift; later steps carry exactly one
   assign bus.pe_en       = state_q == STEP;
   assign bus.shift_right = (state_q == STEP) && !first_q && (dir_q == DIR_R);
   assign bus.shift_down  = (state_q == STEP) && !first_q && (dir_q == DIR_D);
   assign bus.busy        = (state_q == STEP) || (state_q == WAIT);
   assign bus.done        = state_q == FIN;
   assign bus.done_reason = done_reason_q;
   assign bus.best_score  = best_score_q;
   assign bus.best_ref    = best_ref_q;
   assign bus.best_qry    = best_qry_q;
   assign bus.step_cnt    = step_cnt_q;
endmodule

// File: tb/tb_bsw_band_ctrl.sv
// Self-checking bench for bsw_band_ctrl: a max-unit responder plus a behavioural alignment model.
// Two instances share stimulus; the second has a step limit of 5.
module tb_bsw_band_ctrl;
   localparam int LEN_W = 10;

   logic             clk, rst_n, sel, start;
   logic [LEN_W-1:0] ref_len, qry_len;
   logic             ma_valid, r_shift, d_shift;
   logic [6:0]       ma_out;
   logic [3:0]       ma_p;

   logic             pe_en_o, sr_o, sd_o, busy_o, done_o;
   logic [1:0]       reason_o;
   logic [6:0]       best_o;
   logic [LEN_W-1:0] bref_o, bqry_o;
   logic [LEN_W:0]   stepcnt_o;

   int errors, checks;
   int proto_err, dir_mismatch, obs_first_down, obs_pe_cnt;
   int exp_steps, exp_reason, exp_best, exp_bref, exp_bqry;
   int obs_dir_q[$];
   logic             obs_done_at, obs_busy_at_done, obs_done_after, obs_busy_after;
   logic [1:0]       obs_reason, obs_reason_hold;
   logic [6:0]       obs_best;
   logic [LEN_W-1:0] obs_bref, obs_bqry;
   logic [LEN_W:0]   obs_stepcnt;

   bsw_band_ctrl_if #(.LEN_W(LEN_W)) bus_a ();
   bsw_band_ctrl_if #(.LEN_W(LEN_W)) bus_b ();

   bsw_band_ctrl #(.LEN_W(LEN_W), .XDROP(20), .MAX_STEPS(1023)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
   bsw_band_ctrl #(.LEN_W(LEN_W), .XDROP(20), .MAX_STEPS(5)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

   assign bus_a.start    = start && !sel;
   assign bus_b.start    = start && sel;
   assign bus_a.ref_len  = ref_len;
   assign bus_b.ref_len  = ref_len;
   assign bus_a.qry_len  = qry_len;
   assign bus_b.qry_len  = qry_len;
   assign bus_a.ma_valid = ma_valid;
   assign bus_b.ma_valid = ma_valid;
   assign bus_a.ma_out   = ma_out;
   assign bus_b.ma_out   = ma_out;
   assign bus_a.ma_p     = ma_p;
   assign bus_b.ma_p     = ma_p;
   assign bus_a.r_shift  = r_shift;
   assign bus_b.r_shift  = r_shift;
   assign bus_a.d_shift  = d_shift;
   assign bus_b.d_shift  = d_shift;

   assign pe_en_o   = sel ? bus_b.pe_en       : bus_a.pe_en;
   assign sr_o      = sel ? bus_b.shift_right : bus_a.shift_right;
   assign sd_o      = sel ? bus_b.shift_down  : bus_a.shift_down;
   assign busy_o    = sel ? bus_b.busy        : bus_a.busy;
   assign done_o    = sel ? bus_b.done        : bus_a.done;
   assign reason_o  = sel ? bus_b.done_reason : bus_a.done_reason;
   assign best_o    = sel ? bus_b.best_score  : bus_a.best_score;
   assign bref_o    = sel ? bus_b.best_ref    : bus_a.best_ref;
   assign bqry_o    = sel ? bus_b.best_qry    : bus_a.best_qry;
   assign stepcnt_o = sel ? bus_b.step_cnt    : bus_a.step_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Runs one alignment: answers every pe_en like the max unit and predicts the band walk
   // from pointer arithmetic (dir: 0 none, 1 right, 2 down)
   task automatic run_align(input int rl, input int ql, input int hint_mode, input int score_mode,
                            input int s0, input int s1, input int fixed_p, input int max_steps,
                            input bit inject_start, input bit start_at_done);
      int rp, qp, best, bref, bqry, mdir, nsteps, mo, mp, rs, ds, obs_dir;
      bit first, fin, cr, cd;
      rp = 0; qp = 0; best = 0; bref = 0; bqry = 0; mdir = 2; nsteps = 0;
      first = 1'b1; fin = 1'b0;
      proto_err = 0; dir_mismatch = 0; obs_first_down = 0; obs_pe_cnt = 0; exp_reason = -1;
      obs_dir_q.delete();
      obs_done_at = 1'b0; obs_busy_at_done = 1'b1; obs_done_after = 1'b1; obs_busy_after = 1'b1;
      @(negedge clk);
      ref_len = 10'(rl); qry_len = 10'(ql); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!fin) begin
         if (pe_en_o !== 1'b1) begin
            proto_err++;
            break;
         end
         nsteps++; obs_pe_cnt++;
         obs_dir = int'({sd_o, sr_o});
         obs_dir_q.push_back(obs_dir);
         if (sd_o === 1'b1 && obs_first_down == 0) obs_first_down = nsteps;
         if (first) begin
            if (obs_dir != 0) dir_mismatch++;
            first = 1'b0;
         end else begin
            if (obs_dir != mdir) dir_mismatch++;
            if (mdir == 1) rp++; else qp++;
         end
         repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            if (pe_en_o === 1'b1) obs_pe_cnt++;
            if (inject_start) start = 1'b1;
         end
         case (score_mode)
            0:       mo = (nsteps > 127) ? 127 : nsteps;
            1:       mo = 30;
            2:       mo = int'($urandom_range(40, 63));
            default: mo = (nsteps == 1) ? s0 : s1;
         endcase
         mp = (fixed_p >= 0) ? fixed_p : int'($urandom_range(0, 15));
         case (hint_mode)
            0:       begin rs = 0; ds = 0; end
            1:       begin rs = 1; ds = 0; end
            default: begin rs = int'($urandom_range(0, 1)); ds = int'($urandom_range(0, 1)); end
         endcase
         ma_out = 7'(mo); ma_p = 4'(mp); r_shift = 1'(rs); d_shift = 1'(ds); ma_valid = 1'b1;
         if (mo > best) begin
            best = mo;
            bref = (rp + mp) % 1024;
            bqry = (qp + 15 - mp) % 1024;
         end
         cr = (rp + 16 < rl);
         cd = (qp + 16 < ql);
         if (best - mo > 20) begin fin = 1'b1; exp_reason = 1; end
         else if (nsteps == max_steps) begin fin = 1'b1; exp_reason = 2; end
         else if (!cr && !cd) begin fin = 1'b1; exp_reason = 0; end
         if (rs == 1 && ds == 0 && cr) mdir = 1;
         else if (ds == 1 && rs == 0 && cd) mdir = 2;
         else if (cr && !cd) mdir = 1;
         else if (cd && !cr) mdir = 2;
         else mdir = (mdir == 1) ? 2 : 1;
         @(negedge clk);
         ma_valid = 1'b0; r_shift = 1'b0; d_shift = 1'b0; start = 1'b0;
         if (fin) begin
            obs_done_at = done_o; obs_busy_at_done = busy_o; obs_reason = reason_o;
            obs_best = best_o; obs_bref = bref_o; obs_bqry = bqry_o; obs_stepcnt = stepcnt_o;
            if (start_at_done) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            obs_done_after = done_o; obs_busy_after = busy_o;
            repeat (2) @(negedge clk);
            obs_reason_hold = reason_o;
         end
         if (nsteps >= 1100) begin
            proto_err++;
            break;
         end
      end
      exp_steps = nsteps; exp_best = best; exp_bref = bref; exp_bqry = bqry;
      if (busy_o !== 1'b0) begin
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus_a.pe_en, bus_a.shift_right, bus_a.shift_down, bus_a.busy, bus_a.done} !== 5'b0) begin
         errors++; $display("[TB] FAIL reset_ctrl_a: got %b expected 00000",
            {bus_a.pe_en, bus_a.shift_right, bus_a.shift_down, bus_a.busy, bus_a.done});
      end
      checks++;
      if ({bus_a.done_reason, bus_a.best_score, bus_a.best_ref, bus_a.best_qry, bus_a.step_cnt} !== '0) begin
         errors++; $display("[TB] FAIL reset_data_a: got %h expected 0",
            {bus_a.done_reason, bus_a.best_score, bus_a.best_ref, bus_a.best_qry, bus_a.step_cnt});
      end
      checks++;
      if ({bus_b.pe_en, bus_b.busy, bus_b.done, bus_b.best_score, bus_b.step_cnt} !== '0) begin
         errors++; $display("[TB] FAIL reset_b: got %h expected 0",
            {bus_b.pe_en, bus_b.busy, bus_b.done, bus_b.best_score, bus_b.step_cnt});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_window();
      run_align(16, 16, 0, 3, 5, 5, 3, 1023, 1'b0, 1'b0);
      checks++;
      if (proto_err !== 0 || obs_pe_cnt !== 1) begin
         errors++; $display("[TB] FAIL single_steps: got %0d pe_en (proto %0d) expected 1", obs_pe_cnt, proto_err);
      end
      checks++;
      if (dir_mismatch !== 0) begin
         errors++; $display("[TB] FAIL single_shift: got %0d shifted steps expected 0", dir_mismatch);
      end
      checks++;
      if (obs_done_at !== 1'b1 || obs_busy_at_done !== 1'b0 || obs_done_after !== 1'b0) begin
         errors++; $display("[TB] FAIL single_done: got done %b busy %b next %b expected 1 0 0",
            obs_done_at, obs_busy_at_done, obs_done_after);
      end
      checks++;
      if (obs_reason !== 2'd0) begin
         errors++; $display("[TB] FAIL single_reason: got %0d expected 0", obs_reason);
      end
      checks++;
      if (obs_best !== 7'd5 || obs_bref !== 10'd3 || obs_bqry !== 10'd12) begin
         errors++; $display("[TB] FAIL single_best: got %0d@(%0d,%0d) expected 5@(3,12)", obs_best, obs_bref, obs_bqry);
      end
      checks++;
      if (obs_stepcnt !== 11'd1) begin
         errors++; $display("[TB] FAIL single_step_cnt: got %0d expected 1", obs_stepcnt);
      end
      run_align(5, 9, 0, 2, 0, 0, -1, 1023, 1'b0, 1'b0);
      checks++;
      if (obs_pe_cnt !== 1 || obs_reason !== 2'd0 || obs_stepcnt !== 11'd1) begin
         errors++; $display("[TB] FAIL short_seq: got %0d steps reason %0d expected 1 steps reason 0", obs_pe_cnt, obs_reason);
      end
   endtask

   task automatic test_right_then_down();
      run_align(40, 40, 1, 0, 0, 0, -1, 1023, 1'b0, 1'b0);
      checks++;
      if (proto_err !== 0 || obs_pe_cnt !== 49) begin
         errors++; $display("[TB] FAIL rd_steps: got %0d pe_en (proto %0d) expected 49", obs_pe_cnt, proto_err);
      end
      checks++;
      if (dir_mismatch !== 0) begin
         errors++; $display("[TB] FAIL rd_dirs: got %0d wrong steps expected 0", dir_mismatch);
      end
      checks++;
      if (obs_first_down !== 26) begin
         errors++; $display("[TB] FAIL rd_first_down: got step %0d expected 26", obs_first_down);
      end
      checks++;
      if (obs_reason !== 2'd0 || obs_stepcnt !== 11'd49) begin
         errors++; $display("[TB] FAIL rd_end: got reason %0d step_cnt %0d expected 0 49", obs_reason, obs_stepcnt);
      end
      checks++;
      if (obs_best !== 7'd49 || obs_bref !== 10'(exp_bref) || obs_bqry !== 10'(exp_bqry)) begin
         errors++; $display("[TB] FAIL rd_best: got %0d@(%0d,%0d) expected 49@(%0d,%0d)",
            obs_best, obs_bref, obs_bqry, exp_bref, exp_bqry);
      end
   endtask

   task automatic test_alternate();
      run_align(100, 100, 0, 1, 0, 0, -1, 1023, 1'b0, 1'b0);
      checks++;
      if (proto_err !== 0 || obs_pe_cnt !== 169) begin
         errors++; $display("[TB] FAIL alt_steps: got %0d pe_en (proto %0d) expected 169", obs_pe_cnt, proto_err);
      end
      checks++;
      if (obs_dir_q.size() < 5 || obs_dir_q[1] != 1 || obs_dir_q[2] != 2 || obs_dir_q[3] != 1 || obs_dir_q[4] != 2) begin
         errors++; $display("[TB] FAIL alt_pattern: got %0d moves, wrong first directions expected R D R D", obs_dir_q.size());
      end
      checks++;
      if (dir_mismatch !== 0) begin
         errors++; $display("[TB] FAIL alt_dirs: got %0d wrong steps expected 0", dir_mismatch);
      end
      checks++;
      if (obs_best !== 7'd30 || obs_bref !== 10'(exp_bref) || obs_bqry !== 10'(exp_bqry)) begin
         errors++; $display("[TB] FAIL alt_ties: got %0d@(%0d,%0d) expected 30@(%0d,%0d)",
            obs_best, obs_bref, obs_bqry, exp_bref, exp_bqry);
      end
      checks++;
      if (obs_reason !== 2'd0) begin
         errors++; $display("[TB] FAIL alt_reason: got %0d expected 0", obs_reason);
      end
   endtask

   task automatic test_xdrop();
      run_align(16, 40, 0, 3, 50, 29, -1, 1023, 1'b0, 1'b1);
      checks++;
      if (obs_pe_cnt !== 2 || obs_reason !== 2'd1 || obs_best !== 7'd50) begin
         errors++; $display("[TB] FAIL xdrop_hit: got %0d steps reason %0d best %0d expected 2 1 50",
            obs_pe_cnt, obs_reason, obs_best);
      end
      checks++;
      if (obs_done_at !== 1'b1 || obs_busy_after !== 1'b0) begin
         errors++; $display("[TB] FAIL start_at_done: got done %b busy_after %b expected 1 0", obs_done_at, obs_busy_after);
      end
      run_align(16, 40, 0, 3, 50, 30, -1, 1023, 1'b0, 1'b0);
      checks++;
      if (proto_err !== 0 || obs_pe_cnt !== 25 || obs_reason !== 2'd0) begin
         errors++; $display("[TB] FAIL xdrop_edge: got %0d steps reason %0d expected 25 0", obs_pe_cnt, obs_reason);
      end
      checks++;
      if (obs_best !== 7'd50 || obs_reason_hold !== 2'd0) begin
         errors++; $display("[TB] FAIL xdrop_hold: got best %0d reason %0d expected 50 0", obs_best, obs_reason_hold);
      end
   endtask

   task automatic test_step_limit();
      sel = 1'b1;
      run_align(200, 200, 0, 1, 0, 0, -1, 5, 1'b1, 1'b0);
      checks++;
      if (proto_err !== 0 || obs_pe_cnt !== 5) begin
         errors++; $display("[TB] FAIL limit_steps: got %0d pe_en (proto %0d) expected 5", obs_pe_cnt, proto_err);
      end
      checks++;
      if (obs_reason !== 2'd2 || obs_stepcnt !== 11'd5) begin
         errors++; $display("[TB] FAIL limit_reason: got %0d step_cnt %0d expected 2 5", obs_reason, obs_stepcnt);
      end
      checks++;
      if (dir_mismatch !== 0) begin
         errors++; $display("[TB] FAIL limit_dirs: got %0d wrong steps expected 0", dir_mismatch);
      end
      sel = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         run_align(int'($urandom_range(1, 80)), int'($urandom_range(1, 80)), 2, 2, 0, 0, -1, 1023, 1'b0, 1'b0);
         checks++;
         if (proto_err !== 0 || obs_pe_cnt !== exp_steps || obs_stepcnt !== 11'(exp_steps)) begin
            errors++; $display("[TB] FAIL rand_steps[%0d]: got %0d/%0d expected %0d", it, obs_pe_cnt, obs_stepcnt, exp_steps);
         end
         checks++;
         if (dir_mismatch !== 0) begin
            errors++; $display("[TB] FAIL rand_dirs[%0d]: got %0d wrong steps expected 0", it, dir_mismatch);
         end
         checks++;
         if (obs_reason !== 2'(exp_reason)) begin
            errors++; $display("[TB] FAIL rand_reason[%0d]: got %0d expected %0d", it, obs_reason, exp_reason);
         end
         checks++;
         if (obs_best !== 7'(exp_best) || obs_bref !== 10'(exp_bref) || obs_bqry !== 10'(exp_bqry)) begin
            errors++; $display("[TB] FAIL rand_best[%0d]: got %0d@(%0d,%0d) expected %0d@(%0d,%0d)", it,
               obs_best, obs_bref, obs_bqry, exp_best, exp_bref, exp_bqry);
         end
      end
   endtask

   task automatic test_reset_mid();
      int done_cnt;
      sel = 1'b0;
      @(negedge clk);
      ref_len = 10'd200; qry_len = 10'd200; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      ma_out = 7'd100; ma_p = 4'd2; ma_valid = 1'b1;
      @(negedge clk);
      ma_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (best_o !== 7'd100 || busy_o !== 1'b1) begin
         errors++; $display("[TB] FAIL pre_reset: got best %0d busy %b expected 100 1", best_o, busy_o);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({pe_en_o, busy_o, done_o, reason_o, best_o, bref_o, bqry_o, stepcnt_o} !== '0) begin
         errors++; $display("[TB] FAIL async_reset: got %h expected 0",
            {pe_en_o, busy_o, done_o, reason_o, best_o, bref_o, bqry_o, stepcnt_o});
      end
      done_cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (done_o !== 1'b0) done_cnt++;
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (done_o !== 1'b0) done_cnt++;
      end
      checks++;
      if (done_cnt !== 0) begin
         errors++; $display("[TB] FAIL reset_no_done: got %0d done cycles expected 0", done_cnt);
      end
      run_align(16, 16, 0, 3, 5, 5, 7, 1023, 1'b0, 1'b0);
      checks++;
      if (obs_pe_cnt !== 1 || obs_best !== 7'd5 || obs_bref !== 10'd7 || obs_bqry !== 10'd8) begin
         errors++; $display("[TB] FAIL post_reset_run: got %0d steps best %0d@(%0d,%0d) expected 1 5@(7,8)",
            obs_pe_cnt, obs_best, obs_bref, obs_bqry);
      end
   endtask

   initial begin
      errors = 0; checks = 0;
      sel = 1'b0; start = 1'b0; ref_len = '0; qry_len = '0;
      ma_valid = 1'b0; ma_out = '0; ma_p = '0; r_shift = 1'b0; d_shift = 1'b0;
      rst_n = 1'b0;
      test_reset();
      test_single_window();
      test_right_then_down();
      test_alternate();
      test_xdrop();
      test_step_limit();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end
endmodule
